// File: rtl/memory_bus_responder_if.sv
// Load/store request channels plus the single-port req/ack memory bus seen by memory_bus_responder.
interface memory_bus_responder_if;
  logic        load_request_i;
  logic [31:0] load_address_i;
  logic [31:0] load_data_o;
  logic        load_done_o;
  logic        load_error_o;
  logic        store_request_i;
  logic [31:0] store_address_i;
  logic [31:0] store_data_i;
  logic [1:0]  store_width_i;
  logic        store_done_o;
  logic        store_error_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport slave (
    input  load_request_i, load_address_i,
    input  store_request_i, store_address_i, store_data_i, store_width_i,
    input  mem_rdata_i, mem_ack_i,
    output load_data_o, load_done_o, load_error_o,
    output store_done_o, store_error_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  modport master (
    output load_request_i, load_address_i,
    output store_request_i, store_address_i, store_data_i, store_width_i,
    output mem_rdata_i, mem_ack_i,
    input  load_data_o, load_done_o, load_error_o,
    input  store_done_o, store_error_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
endinterface

// File: rtl/memory_bus_responder.sv
// Captures one pending load and one pending store and arbitrates them onto a req/ack memory bus,
// reporting completion, bus timeouts and misaligned stores as done/error pulses.
module memory_bus_responder #(
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int LOAD_STREAK_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  memory_bus_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOAD_WAIT  = 2'd1,
    S_STORE_WAIT = 2'd2
  } state_t;

  localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] STREAK_MAX = 8'(LOAD_STREAK_MAX);

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] a);
    case (width)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] width, input logic [1:0] a);
    case (width)
      2'b00:   lane_be = 4'b0001 << a;
      2'b01:   lane_be = 4'b0011 << {a[1], 1'b0};
      default: lane_be = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] width, input logic [31:0] data);
    case (width)
      2'b00:   lane_data = {4{data[7:0]}};
      2'b01:   lane_data = {2{data[15:0]}};
      default: lane_data = data;
    endcase
  endfunction

  state_t      r_state, w_state;
  logic        r_load_pend, w_load_pend;
  logic        r_store_pend, w_store_pend;
  logic [31:0] r_load_addr, w_load_addr_nxt;
  logic [31:0] r_store_addr, w_store_addr_nxt;
  logic [31:0] r_store_data, w_store_data_nxt;
  logic [1:0]  r_store_width, w_store_width_nxt;
  logic [7:0]  r_streak, w_streak;
  logic [9:0]  r_timer, w_timer;
  logic        r_mem_req, w_mem_req;
  logic        r_mem_we, w_mem_we;
  logic [31:0] r_mem_addr, w_mem_addr;
  logic [31:0] r_mem_wdata, w_mem_wdata;
  logic [3:0]  r_mem_be, w_mem_be;
  logic [31:0] r_load_data, w_load_data;
  logic        r_load_done, w_load_done;
  logic        r_load_err, w_load_err;
  logic        r_store_done, w_store_done;
  logic        r_store_err, w_store_err;

  logic        w_load_acc, w_store_hit, w_store_mis, w_store_acc;
  logic        w_load_want, w_store_want;
  logic [31:0] w_ld_addr, w_st_addr, w_st_data;
  logic [1:0]  w_st_width;

  // Request capture, arbitration and bus/completion next-state logic
  always_comb begin
    // A request arriving while IDLE is visible to arbitration in the same cycle it is captured.
    w_load_acc   = bus.load_request_i & ~r_load_pend;
    w_store_hit  = bus.store_request_i & ~r_store_pend;
    w_store_mis  = is_misaligned(bus.store_width_i, bus.store_address_i[1:0]);
    w_store_acc  = w_store_hit & ~w_store_mis;
    w_load_want  = r_load_pend | w_load_acc;
    w_store_want = r_store_pend | w_store_acc;
    w_ld_addr    = r_load_pend  ? r_load_addr   : bus.load_address_i;
    w_st_addr    = r_store_pend ? r_store_addr  : bus.store_address_i;
    w_st_data    = r_store_pend ? r_store_data  : bus.store_data_i;
    w_st_width   = r_store_pend ? r_store_width : bus.store_width_i;

    w_state           = r_state;
    w_load_pend       = w_load_want;
    w_store_pend      = w_store_want;
    w_load_addr_nxt   = w_ld_addr;
    w_store_addr_nxt  = w_st_addr;
    w_store_data_nxt  = w_st_data;
    w_store_width_nxt = w_st_width;
    w_streak          = r_streak;
    w_timer           = r_timer;
    w_mem_req         = r_mem_req;
    w_mem_we          = r_mem_we;
    w_mem_addr        = r_mem_addr;
    w_mem_wdata       = r_mem_wdata;
    w_mem_be          = r_mem_be;
    w_load_data       = r_load_data;
    w_load_done       = 1'b0;
    w_load_err        = 1'b0;
    w_store_done      = w_store_hit & w_store_mis;
    w_store_err       = w_store_hit & w_store_mis;

    case (r_state)
      S_IDLE: begin
        w_timer = 10'd0;
        if (w_load_want && (!w_store_want || (r_streak < STREAK_MAX))) begin
          w_state     = S_LOAD_WAIT;
          w_streak    = w_store_want ? (r_streak + 8'd1) : 8'd0;
          w_mem_req   = 1'b1;
          w_mem_we    = 1'b0;
          w_mem_addr  = w_ld_addr & 32'hFFFF_FFFC;
          w_mem_be    = 4'hF;
          w_mem_wdata = 32'h0000_0000;
        end else if (w_store_want) begin
          w_state     = S_STORE_WAIT;
          w_streak    = 8'd0;
          w_mem_req   = 1'b1;
          w_mem_we    = 1'b1;
          w_mem_addr  = w_st_addr & 32'hFFFF_FFFC;
          w_mem_be    = lane_be(w_st_width, w_st_addr[1:0]);
          w_mem_wdata = lane_data(w_st_width, w_st_data);
        end else begin
          w_streak = 8'd0;
        end
      end
      S_LOAD_WAIT: begin
        if (bus.mem_ack_i) begin
          w_state     = S_IDLE;
          w_timer     = 10'd0;
          w_mem_req   = 1'b0;
          w_load_done = 1'b1;
          w_load_data = bus.mem_rdata_i;
          w_load_pend = 1'b0;
        end else if (r_timer == TIMER_LAST) begin
          w_state     = S_IDLE;
          w_timer     = 10'd0;
          w_mem_req   = 1'b0;
          w_load_done = 1'b1;
          w_load_err  = 1'b1;
          w_load_data = 32'h0000_0000;
          w_load_pend = 1'b0;
        end else begin
          w_timer = r_timer + 10'd1;
        end
      end
      S_STORE_WAIT: begin
        if (bus.mem_ack_i) begin
          w_state      = S_IDLE;
          w_timer      = 10'd0;
          w_mem_req    = 1'b0;
          w_store_done = 1'b1;
          w_store_err  = 1'b0;
          w_store_pend = 1'b0;
        end else if (r_timer == TIMER_LAST) begin
          w_state      = S_IDLE;
          w_timer      = 10'd0;
          w_mem_req    = 1'b0;
          w_store_done = 1'b1;
          w_store_err  = 1'b1;
          w_store_pend = 1'b0;
        end else begin
          w_timer = r_timer + 10'd1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State, pending captures and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_load_pend   <= 1'b0;
      r_store_pend  <= 1'b0;
      r_load_addr   <= 32'h0000_0000;
      r_store_addr  <= 32'h0000_0000;
      r_store_data  <= 32'h0000_0000;
      r_store_width <= 2'b00;
      r_streak      <= 8'd0;
      r_timer       <= 10'd0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 32'h0000_0000;
      r_mem_wdata   <= 32'h0000_0000;
      r_mem_be      <= 4'h0;
      r_load_data   <= 32'h0000_0000;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
      r_store_done  <= 1'b0;
      r_store_err   <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_load_pend   <= w_load_pend;
      r_store_pend  <= w_store_pend;
      r_load_addr   <= w_load_addr_nxt;
      r_store_addr  <= w_store_addr_nxt;
      r_store_data  <= w_store_data_nxt;
      r_store_width <= w_store_width_nxt;
      r_streak      <= w_streak;
      r_timer       <= w_timer;
      r_mem_req     <= w_mem_req;
      r_mem_we      <= w_mem_we;
      r_mem_addr    <= w_mem_addr;
      r_mem_wdata   <= w_mem_wdata;
      r_mem_be      <= w_mem_be;
      r_load_data   <= w_load_data;
      r_load_done   <= w_load_done;
      r_load_err    <= w_load_err;
      r_store_done  <= w_store_done;
      r_store_err   <= w_store_err;
    end
  end

  assign bus.mem_req_o     = r_mem_req;
  assign bus.mem_we_o      = r_mem_we;
  assign bus.mem_addr_o    = r_mem_addr;
  assign bus.mem_wdata_o   = r_mem_wdata;
  assign bus.mem_be_o      = r_mem_be;
  assign bus.load_data_o   = r_load_data;
  assign bus.load_done_o   = r_load_done;
  assign bus.load_error_o  = r_load_err;
  assign bus.store_done_o  = r_store_done;
  assign bus.store_error_o = r_store_err;

endmodule
